fpu_seq: RTL and testbench
==========================

Name: fpu_seq

Overview:
- Issue/sequencing controller between the core's execute stage and the RV32F datapath.
- Accepts one FP instruction at a time and resolves the dynamic rounding mode against frm.
- Rejects reserved rounding modes as illegal.
- Single-cycle ops: captures the combinational FPU result.
- FDIV/FSQRT: dispatches to an iterative unit over a start/done handshake, with a watchdog timeout.
- Presents every result to the core over a valid/ready response port and drives busy_o for pipeline stall.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles to wait for itr_done_i after itr_start_o before aborting.
- CNT_W, 7: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  core presents an FP instruction.
- req_ready_o  out  1  sequencer accepts the request this cycle.
- instr_i  in  32  FP instruction word (opcode in [6:0], rm in [14:12], funct5 in [31:27]).
- frm_i  in  3  fcsr.frm.
- flush_i  in  1  pipeline flush; abort any in-flight op.
- fpu_enable_o  out  1  enables the combinational FPU in the accept cycle.
- fpu_rm_o  out  3  resolved rounding mode to the FPU and iterative unit (combinational from instr_i/frm_i).
- comb_result_i  in  32  combinational FPU output.
- itr_start_o  out  1  one-cycle start pulse to the div/sqrt unit.
- itr_op_o  out  1  0 = FDIV, 1 = FSQRT; stable from start until done or abort.
- itr_abort_o  out  1  one-cycle abort pulse to the div/sqrt unit.
- itr_done_i  in  1  div/sqrt result valid (single-cycle pulse).
- itr_result_i  in  32  div/sqrt result.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  core consumes the response.
- resp_result_o  out  32  result word.
- resp_illegal_o  out  1  illegal rounding mode; result is 0.
- resp_timeout_o  out  1  watchdog fired; result is canonical NaN.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, reset_i high at an edge):
  - State goes to IDLE and the counter clears.
  - resp_valid_o, resp_illegal_o, resp_timeout_o, itr_start_o, itr_abort_o, itr_op_o, busy_o all 0; resp_result_o = 0.
  - No itr_abort_o pulse is issued on reset mid-op; the iterative unit shares reset_i.
- rm resolution:
  - raw = instr_i[14:12]; resolved = (raw == 3'b111) ? frm_i : raw.
  - illegal = uses_rm && (resolved == 101, 110 or 111).
  - uses_rm: FMA-class (instr_i[4] == 0), or funct5 in {00000, 00001, 00010, 00011, 01011, 11000, 11010}.
- Iterative op: instr_i[4] == 1 and funct5 in {00011 (FDIV), 01011 (FSQRT)}.
- Handshake:
  - req_ready_o = (state == IDLE) && !flush_i.
  - Accept occurs when req_valid_i && req_ready_o.
  - fpu_enable_o = accept && !illegal && !iterative.
- States IDLE, ITER, RESP.
  - IDLE:
    - On accept of an illegal op: load result 0, illegal = 1; go to RESP.
    - On accept of a non-iterative op: capture comb_result_i; go to RESP. Latency: resp_valid_o rises the cycle after accept.
    - On accept of an iterative op: latch itr_op_o; go to ITER; itr_start_o pulses in the first ITER cycle; counter = 0.
  - ITER:
    - Counter increments each cycle.
    - On itr_done_i: capture itr_result_i; go to RESP. itr_done_i in the start cycle is legal.
    - Else, when counter == TIMEOUT_CYCLES-1: pulse itr_abort_o, result = 32'h7FC00000, timeout = 1; go to RESP.
  - RESP:
    - Response outputs held stable while resp_valid_o && !resp_ready_i.
    - On resp_ready_i: go to IDLE; clear resp_valid_o and flags.
    - Minimum issue interval is 2 cycles.
- flush_i has highest priority after reset:
  - Any state goes to IDLE; a pending response is dropped.
  - In ITER: itr_abort_o pulses the next cycle and itr_done_i in the same cycle is ignored.
  - flush_i with req_valid_i: the request is not accepted.
- itr_done_i outside ITER is ignored.
- busy_o = (state != IDLE).

Decomposition:
- Package fpu_pkg:
  - State enum {IDLE, ITER, RESP}.
  - funct5 constants FADD/FSUB/FMUL/FDIV/FSQRT/FCVTWS/FCVTSW.
  - RM_DYN = 3'b111.
  - CANON_NAN = 32'h7FC00000.
- One sub-module fpu_rm_decode (combinational):
  - Inputs: instr, frm.
  - Outputs: resolved rm, illegal, iterative, op.
  - Reused later by the decode stage.

Test Plan:
- Combinational op: FADD with rm=000, comb_result_i=32'h40400000 → resp_valid_o the cycle after accept, result 40400000, fpu_rm_o=000, busy_o high for 1 cycle.
- Dynamic rm: FMUL with rm=111, frm_i=010 → fpu_rm_o=010, normal response; repeat with frm_i=101 → resp_illegal_o=1, result 0, fpu_enable_o never high.
- FDIV: itr_done_i 12 cycles after start with itr_result_i=32'h3F000000 → single itr_start_o pulse, itr_op_o=0, response 3F000000; resp_ready_i held low 3 cycles → outputs stable.
- Watchdog: FSQRT with no itr_done_i → itr_abort_o at cycle TIMEOUT_CYCLES after start, resp_timeout_o=1, result 7FC00000.
- Flush: flush_i during ITER coinciding with itr_done_i → no response, itr_abort_o one pulse, req_ready_o high next cycle.
- Reset: reset_i during ITER → all outputs 0 next cycle, no itr_abort_o; a new FADD then completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the RV32F issue sequencer and its decode helpers.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        RESP = 2'd2
    } seqState_t;

    // funct5 field values (instr[31:27]) of the OP-FP instructions the sequencer cares about.
    localparam logic [4:0] FADD   = 5'b00000;
    localparam logic [4:0] FSUB   = 5'b00001;
    localparam logic [4:0] FMUL   = 5'b00010;
    localparam logic [4:0] FDIV   = 5'b00011;
    localparam logic [4:0] FSQRT  = 5'b01011;
    localparam logic [4:0] FCVTWS = 5'b11000;
    localparam logic [4:0] FCVTSW = 5'b11010;

    localparam logic [2:0]  RM_DYN    = 3'b111;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    // Encodings 101/110 are reserved; 111 left unresolved (frm itself holding DYN) is illegal too.
    function automatic logic isReservedRm(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

// File: rtl/fpu_rm_decode.sv
// Rounding-mode resolution and op classification for one FP instruction word.
module fpu_rm_decode (
    input  logic [31:0] instr,
    input  logic [2:0]  frm,
    output logic [2:0]  rm,
    output logic        illegal,
    output logic        iterative,
    output logic        op
);
    import fpu_pkg::*;

    logic [4:0] funct5;
    logic [2:0] rawRm;
    logic       isOpFp;
    logic       usesRm;
    logic       unusedBits;

    assign funct5 = instr[31:27];
    assign rawRm  = instr[14:12];
    assign isOpFp = instr[4];

    assign rm = (rawRm == RM_DYN) ? frm : rawRm;

    // FMA-class opcodes (bit 4 clear) always carry an rm field.
    assign usesRm = !isOpFp
                  || (funct5 == FADD)  || (funct5 == FSUB)   || (funct5 == FMUL)
                  || (funct5 == FDIV)  || (funct5 == FSQRT)
                  || (funct5 == FCVTWS) || (funct5 == FCVTSW);

    assign illegal   = usesRm && isReservedRm(rm);
    assign iterative = isOpFp && ((funct5 == FDIV) || (funct5 == FSQRT));
    assign op        = (funct5 == FSQRT);

    assign unusedBits = ^{instr[26:15], instr[11:5], instr[3:0]};

endmodule

// File: rtl/fpu_seq.sv
// Issue/sequencing controller between the execute stage and the RV32F datapath:
// single-cycle ops capture the combinational FPU, FDIV/FSQRT go through a start/done handshake.
module fpu_seq #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7   // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] instr_i,
    input  logic [2:0]  frm_i,
    input  logic        flush_i,
    output logic        fpu_enable_o,
    output logic [2:0]  fpu_rm_o,
    input  logic [31:0] comb_result_i,
    output logic        itr_start_o,
    output logic        itr_op_o,
    output logic        itr_abort_o,
    input  logic        itr_done_i,
    input  logic [31:0] itr_result_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_result_o,
    output logic        resp_illegal_o,
    output logic        resp_timeout_o,
    output logic        busy_o
);
    import fpu_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seqState_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [31:0]      result, resultNext;
    logic             illegalQ, illegalNext;
    logic             timeoutQ, timeoutNext;
    logic             itrOpQ, itrOpNext;
    logic             startQ, startNext;
    logic             abortQ, abortNext;

    logic [2:0]       decRm;
    logic             decIllegal;
    logic             decIter;
    logic             decOp;
    logic             accept;

    fpu_rm_decode u_rm_decode (
        .instr     (instr_i),
        .frm       (frm_i),
        .rm        (decRm),
        .illegal   (decIllegal),
        .iterative (decIter),
        .op        (decOp)
    );

    assign req_ready_o  = (state == IDLE) && !flush_i;
    assign accept       = req_valid_i && req_ready_o;
    assign fpu_enable_o = accept && !decIllegal && !decIter;
    assign fpu_rm_o     = decRm;

    always_comb begin
        // NOTE: every next-value gets a default before any branch, so no latch is inferred.
        stateNext   = state;
        cntNext     = cnt;
        resultNext  = result;
        illegalNext = illegalQ;
        timeoutNext = timeoutQ;
        itrOpNext   = itrOpQ;
        startNext   = 1'b0;
        abortNext   = 1'b0;

        if (flush_i) begin
            // Drop whatever is pending; an in-flight divide/sqrt is told to stop next cycle.
            stateNext   = IDLE;
            illegalNext = 1'b0;
            timeoutNext = 1'b0;
            abortNext   = (state == ITER);
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (decIllegal) begin
                            resultNext  = '0;
                            illegalNext = 1'b1;
                            stateNext   = RESP;
                        end else if (decIter) begin
                            itrOpNext = decOp;
                            cntNext   = '0;
                            startNext = 1'b1;
                            stateNext = ITER;
                        end else begin
                            resultNext = comb_result_i;
                            stateNext  = RESP;
                        end
                    end
                end
                ITER: begin
                    cntNext = cnt + CNT_W'(1);
                    if (itr_done_i) begin
                        resultNext = itr_result_i;
                        stateNext  = RESP;
                    end else if (cnt == CNT_LAST) begin
                        abortNext   = 1'b1;
                        resultNext  = CANON_NAN;
                        timeoutNext = 1'b1;
                        stateNext   = RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        stateNext   = IDLE;
                        illegalNext = 1'b0;
                        timeoutNext = 1'b0;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and only acts at an edge.
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= '0;
            result   <= '0;
            illegalQ <= 1'b0;
            timeoutQ <= 1'b0;
            itrOpQ   <= 1'b0;
            startQ   <= 1'b0;
            abortQ   <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            result   <= resultNext;
            illegalQ <= illegalNext;
            timeoutQ <= timeoutNext;
            itrOpQ   <= itrOpNext;
            startQ   <= startNext;
            abortQ   <= abortNext;
        end
    end

    assign itr_start_o    = startQ;
    assign itr_abort_o    = abortQ;
    assign itr_op_o       = itrOpQ;
    assign resp_valid_o   = (state == RESP);
    assign resp_result_o  = result;
    assign resp_illegal_o = illegalQ;
    assign resp_timeout_o = timeoutQ;
    assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_fpu_seq.sv
// Directed self-checking bench for fpu_seq: one task per scenario, inline comparisons.
module tb_fpu_seq;

    localparam int TO = 64;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_MUL  = 5'b00010;
    localparam logic [4:0] F_DIV  = 5'b00011;
    localparam logic [4:0] F_SQRT = 5'b01011;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] instr_i;
    logic [2:0]  frm_i;
    logic        flush_i;
    logic        fpu_enable_o;
    logic [2:0]  fpu_rm_o;
    logic [31:0] comb_result_i;
    logic        itr_start_o;
    logic        itr_op_o;
    logic        itr_abort_o;
    logic        itr_done_i;
    logic [31:0] itr_result_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_result_o;
    logic        resp_illegal_o;
    logic        resp_timeout_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    fpu_seq #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .instr_i        (instr_i),
        .frm_i          (frm_i),
        .flush_i        (flush_i),
        .fpu_enable_o   (fpu_enable_o),
        .fpu_rm_o       (fpu_rm_o),
        .comb_result_i  (comb_result_i),
        .itr_start_o    (itr_start_o),
        .itr_op_o       (itr_op_o),
        .itr_abort_o    (itr_abort_o),
        .itr_done_i     (itr_done_i),
        .itr_result_i   (itr_result_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_result_o  (resp_result_o),
        .resp_illegal_o (resp_illegal_o),
        .resp_timeout_o (resp_timeout_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mkInstr(input logic [4:0] f5, input logic [2:0] rm);
        return {f5, 2'b00, 5'd2, 5'd1, rm, 5'd3, 7'b1010011};
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        reset_i = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; itr_done_i = 1'b0;
        resp_ready_i = 1'b0; instr_i = '0; frm_i = '0; comb_result_i = '0; itr_result_i = '0;
        tick; tick;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, resp_valid_o, resp_illegal_o, resp_timeout_o, itr_start_o, itr_abort_o, itr_op_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000", {busy_o, resp_valid_o, resp_illegal_o, resp_timeout_o, itr_start_o, itr_abort_o, itr_op_o});
        end
        checks++;
        if (resp_result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", resp_result_o); end
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
    endtask

    task automatic test_comb_op;
        instr_i = mkInstr(F_ADD, 3'b000); comb_result_i = 32'h40400000;
        resp_ready_i = 1'b1; req_valid_i = 1'b1;
        #1;
        checks++;
        if ({req_ready_o, fpu_enable_o, fpu_rm_o} !== 5'b11000) begin
            errors++; $display("FAIL comb_accept: got ready/en/rm %b expected 11000", {req_ready_o, fpu_enable_o, fpu_rm_o});
        end
        tick;
        req_valid_i = 1'b0;
        checks++;
        if ({resp_valid_o, busy_o, resp_illegal_o} !== 3'b110) begin
            errors++; $display("FAIL comb_resp_flags: got valid/busy/ill %b expected 110", {resp_valid_o, busy_o, resp_illegal_o});
        end
        checks++;
        if (resp_result_o !== 32'h40400000) begin errors++; $display("FAIL comb_result: got %h expected 40400000", resp_result_o); end
        tick;
        checks++;
        if ({resp_valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL comb_release: got valid/busy %b expected 00", {resp_valid_o, busy_o}); end
    endtask

    task automatic test_dyn_rm;
        logic enSeen;
        instr_i = mkInstr(F_MUL, 3'b111); frm_i = 3'b010; comb_result_i = 32'h41200000;
        resp_ready_i = 1'b1; req_valid_i = 1'b1;
        #1;
        checks++;
        if ({fpu_rm_o, fpu_enable_o} !== 4'b0101) begin errors++; $display("FAIL dyn_rm_resolve: got rm/en %b expected 0101", {fpu_rm_o, fpu_enable_o}); end
        tick;
        req_valid_i = 1'b0;
        checks++;
        if ({resp_valid_o, resp_illegal_o} !== 2'b10 || resp_result_o !== 32'h41200000) begin
            errors++; $display("FAIL dyn_rm_resp: got valid/ill %b result %h expected 10 41200000", {resp_valid_o, resp_illegal_o}, resp_result_o);
        end
        tick;
        frm_i = 3'b101; req_valid_i = 1'b1;
        #1;
        checks++;
        if (fpu_rm_o !== 3'b101) begin errors++; $display("FAIL dyn_rm_reserved: got %b expected 101", fpu_rm_o); end
        enSeen = fpu_enable_o;
        tick;
        enSeen = enSeen | fpu_enable_o;
        req_valid_i = 1'b0;
        checks++;
        if ({resp_valid_o, resp_illegal_o, resp_timeout_o} !== 3'b110 || resp_result_o !== 32'h0) begin
            errors++; $display("FAIL illegal_resp: got valid/ill/to %b result %h expected 110 00000000", {resp_valid_o, resp_illegal_o, resp_timeout_o}, resp_result_o);
        end
        tick;
        enSeen = enSeen | fpu_enable_o;
        checks++;
        if (enSeen !== 1'b0) begin errors++; $display("FAIL illegal_enable: got %b expected 0", enSeen); end
        frm_i = 3'b000;
    endtask

    task automatic test_fdiv;
        int starts = 0;
        int aborts = 0;
        logic opBad = 1'b0;
        logic early = 1'b0;
        logic unstable = 1'b0;
        instr_i = mkInstr(F_DIV, 3'b000); itr_result_i = 32'h3F000000; comb_result_i = 32'hDEADBEEF;
        resp_ready_i = 1'b0; req_valid_i = 1'b1;
        #1;
        checks++;
        if (fpu_enable_o !== 1'b0) begin errors++; $display("FAIL fdiv_enable: got %b expected 0", fpu_enable_o); end
        tick;
        req_valid_i = 1'b0;
        checks++;
        if ({itr_start_o, itr_op_o, busy_o} !== 3'b101) begin errors++; $display("FAIL fdiv_start: got start/op/busy %b expected 101", {itr_start_o, itr_op_o, busy_o}); end
        for (int k = 0; k < 12; k++) begin
            if (itr_start_o) starts++;
            if (itr_abort_o) aborts++;
            if (itr_op_o !== 1'b0) opBad = 1'b1;
            if (resp_valid_o) early = 1'b1;
            tick;
        end
        itr_done_i = 1'b1;
        checks++;
        if (starts != 1 || opBad || early) begin errors++; $display("FAIL fdiv_iter: got starts=%0d opBad=%b early=%b expected 1 0 0", starts, opBad, early); end
        tick;
        itr_done_i = 1'b0;
        if (itr_abort_o) aborts++;
        checks++;
        if ({resp_valid_o, resp_timeout_o} !== 2'b10 || resp_result_o !== 32'h3F000000 || aborts != 0) begin
            errors++; $display("FAIL fdiv_resp: got valid/to %b result %h aborts %0d expected 10 3f000000 0", {resp_valid_o, resp_timeout_o}, resp_result_o, aborts);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            if (resp_valid_o !== 1'b1 || resp_result_o !== 32'h3F000000 || resp_illegal_o || resp_timeout_o) unstable = 1'b1;
        end
        checks++;
        if (unstable !== 1'b0) begin errors++; $display("FAIL fdiv_hold: got unstable=%b expected 0", unstable); end
        resp_ready_i = 1'b1;
        tick;
        checks++;
        if ({resp_valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL fdiv_release: got valid/busy %b expected 00", {resp_valid_o, busy_o}); end
    endtask

    task automatic test_watchdog;
        int abortCycle = -1;
        int aborts = 0;
        logic opOk = 1'b1;
        instr_i = mkInstr(F_SQRT, 3'b000); resp_ready_i = 1'b0; req_valid_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        for (int k = 0; k < TO + 4; k++) begin
            if (itr_abort_o) begin
                aborts++;
                if (abortCycle < 0) abortCycle = k;
            end
            if (abortCycle < 0 && itr_op_o !== 1'b1) opOk = 1'b0;
            tick;
        end
        checks++;
        if (abortCycle != TO || aborts != 1) begin errors++; $display("FAIL wd_abort: got cycle=%0d pulses=%0d expected %0d 1", abortCycle, aborts, TO); end
        checks++;
        if (opOk !== 1'b1) begin errors++; $display("FAIL wd_op: got op stable=%b expected 1", opOk); end
        checks++;
        if ({resp_valid_o, resp_timeout_o, resp_illegal_o} !== 3'b110 || resp_result_o !== 32'h7FC00000) begin
            errors++; $display("FAIL wd_resp: got valid/to/ill %b result %h expected 110 7fc00000", {resp_valid_o, resp_timeout_o, resp_illegal_o}, resp_result_o);
        end
        resp_ready_i = 1'b1;
        tick;
        checks++;
        if ({resp_valid_o, resp_timeout_o, busy_o} !== 3'b000) begin errors++; $display("FAIL wd_release: got %b expected 000", {resp_valid_o, resp_timeout_o, busy_o}); end
    endtask

    task automatic test_flush;
        instr_i = mkInstr(F_DIV, 3'b000); resp_ready_i = 1'b1; req_valid_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        tick; tick; tick;
        flush_i = 1'b1; itr_done_i = 1'b1; itr_result_i = 32'h12345678;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_iter: got %b expected 0", req_ready_o); end
        tick;
        flush_i = 1'b0; itr_done_i = 1'b0;
        #1;
        checks++;
        if ({resp_valid_o, busy_o, itr_abort_o, req_ready_o} !== 4'b0011) begin
            errors++; $display("FAIL flush_abort: got valid/busy/abort/ready %b expected 0011", {resp_valid_o, busy_o, itr_abort_o, req_ready_o});
        end
        tick;
        checks++;
        if ({itr_abort_o, resp_valid_o} !== 2'b00) begin errors++; $display("FAIL flush_single_abort: got abort/valid %b expected 00", {itr_abort_o, resp_valid_o}); end
        instr_i = mkInstr(F_ADD, 3'b000); flush_i = 1'b1; req_valid_i = 1'b1;
        #1;
        checks++;
        if ({req_ready_o, fpu_enable_o} !== 2'b00) begin errors++; $display("FAIL flush_req_ready: got ready/en %b expected 00", {req_ready_o, fpu_enable_o}); end
        tick;
        flush_i = 1'b0; req_valid_i = 1'b0;
        checks++;
        if ({busy_o, resp_valid_o} !== 2'b00) begin errors++; $display("FAIL flush_no_accept: got busy/valid %b expected 00", {busy_o, resp_valid_o}); end
    endtask

    task automatic test_reset_mid;
        instr_i = mkInstr(F_SQRT, 3'b000); resp_ready_i = 1'b1; req_valid_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        tick; tick;
        checks++;
        if ({busy_o, itr_op_o} !== 2'b11) begin errors++; $display("FAIL rstmid_pre: got busy/op %b expected 11", {busy_o, itr_op_o}); end
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        checks++;
        if ({busy_o, resp_valid_o, itr_start_o, itr_abort_o, itr_op_o, resp_illegal_o, resp_timeout_o} !== 7'b0 || resp_result_o !== 32'h0) begin
            errors++; $display("FAIL rstmid_outputs: got %b result %h expected 0000000 00000000",
                {busy_o, resp_valid_o, itr_start_o, itr_abort_o, itr_op_o, resp_illegal_o, resp_timeout_o}, resp_result_o);
        end
        instr_i = mkInstr(F_ADD, 3'b000); comb_result_i = 32'h3FC00000; req_valid_i = 1'b1;
        #1;
        checks++;
        if (itr_abort_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_abort: got %b expected 0", itr_abort_o); end
        tick;
        req_valid_i = 1'b0;
        checks++;
        if (resp_valid_o !== 1'b1 || resp_result_o !== 32'h3FC00000) begin
            errors++; $display("FAIL rstmid_fadd: got valid %b result %h expected 1 3fc00000", resp_valid_o, resp_result_o);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [5:0]  pattern = '0;
        logic [31:0] lastResult = '0;
        instr_i = mkInstr(F_ADD, 3'b001); comb_result_i = 32'h40000000;
        resp_ready_i = 1'b1; req_valid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pattern[k] = req_ready_o;
            tick;
            if (resp_valid_o) lastResult = resp_result_o;
            if (k == 1) comb_result_i = 32'h40800000;
        end
        req_valid_i = 1'b0;
        checks++;
        if (pattern !== 6'b010101) begin errors++; $display("FAIL b2b_ready_pattern: got %b expected 010101", pattern); end
        checks++;
        if (lastResult !== 32'h40800000) begin errors++; $display("FAIL b2b_result: got %h expected 40800000", lastResult); end
        itr_done_i = 1'b1; itr_result_i = 32'hCAFEF00D;
        tick;
        itr_done_i = 1'b0;
        checks++;
        if ({busy_o, resp_valid_o} !== 2'b00) begin errors++; $display("FAIL done_outside_iter: got busy/valid %b expected 00", {busy_o, resp_valid_o}); end
    endtask

    initial begin
        test_reset;
        test_comb_op;
        test_dyn_rm;
        test_fdiv;
        test_watchdog;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary in time");
        $fatal(1);
    end

endmodule
